// File: rtl/mrd_tlp_sender_pkg.sv
// Shared constants for the MRd64 request path: TLP format/type, chunk size,
// Max_Read_Request_Size codes with their sub-request sizes, and the FSM states.
package mrd_tlp_sender_pkg;

  localparam logic [6:0]  MRD64_FMT_TYPE = 7'b01_00000;
  localparam int unsigned CHUNK_BYTES    = 512;

  typedef enum logic [2:0] {
    MRRS_128B = 3'b000,
    MRRS_256B = 3'b001,
    MRRS_512B = 3'b010
  } mrrs_e;

  localparam int unsigned MRRS_128B_BYTES = 128;
  localparam int unsigned MRRS_256B_BYTES = 256;
  localparam int unsigned MRRS_512B_BYTES = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_HDR1,
    ST_HDR2,
    ST_NPWAIT,
    ST_ACK,
    ST_DONE
  } state_e;

  // Codes above 512 B are clamped: a chunk never needs more than one TLP.
  function automatic logic [9:0] sub_req_dw(input logic [2:0] code);
    case (mrrs_e'(code))
      MRRS_128B: return 10'(MRRS_128B_BYTES / 4);
      MRRS_256B: return 10'(MRRS_256B_BYTES / 4);
      default:   return 10'(MRRS_512B_BYTES / 4);
    endcase
  endfunction

  function automatic logic [2:0] sub_req_count(input logic [2:0] code);
    case (mrrs_e'(code))
      MRRS_128B: return 3'(CHUNK_BYTES / MRRS_128B_BYTES);
      MRRS_256B: return 3'(CHUNK_BYTES / MRRS_256B_BYTES);
      default:   return 3'(CHUNK_BYTES / MRRS_512B_BYTES);
    endcase
  endfunction

endpackage

// File: rtl/mrd_tlp_sender_if.sv
// TRN transmit bus between a TLP source (master) and the PCIe core (slave).
interface mrd_tlp_sender_if;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic        trn_tbuf_av_np;

  modport master (
    output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    input  trn_tdst_rdy_n, trn_tbuf_av_np
  );

  modport slave (
    input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    output trn_tdst_rdy_n, trn_tbuf_av_np
  );
endinterface

// File: rtl/mrd_hdr_build.sv
// Combinational MRd64 header former: beat1 carries fmt/type, length, requester
// ID and tag; beat2 carries the DW-aligned 64-bit address.
module mrd_hdr_build
  import mrd_tlp_sender_pkg::*;
(
  input  logic [9:0]  length,
  input  logic [4:0]  tag,
  input  logic [15:0] requester_id,
  input  logic [63:2] addr,
  output logic [63:0] beat1,
  output logic [63:0] beat2
);

  // TC, TD, EP and attributes are all zero; both byte enables are full.
  assign beat1 = {1'b0, MRD64_FMT_TYPE, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0,
                  2'b00, 2'b00, length,
                  requester_id, {3'b000, tag}, 4'hF, 4'hF};

  assign beat2 = {addr[63:32], addr[31:2], 2'b00};

endmodule

// File: rtl/mrd_tlp_sender.sv
// Splits one 512-byte chunk read into MRd64 TLPs sized by Max_Read_Request_Size
// and drives them onto the shared TRN TX interface when granted.
module mrd_tlp_sender
  import mrd_tlp_sender_pkg::*;
(
  input  logic                    trn_clk,
  input  logic                    reset_n,
  input  logic                    read_chunk,
  input  logic [63:0]             huge_page_addr_read_from,
  output logic                    read_chunk_ack,
  input  logic [15:0]             cfg_completer_id,
  input  logic [2:0]              cfg_max_rd_req_size,
  mrd_tlp_sender_if.master        trn,
  input  logic                    my_turn,
  output logic                    driving_interface
);

  state_e      state, state_nxt;
  logic [63:0] addr_q, addr_nxt;
  logic [9:0]  sub_dw_q, sub_dw_nxt;
  logic [2:0]  rem_q, rem_nxt;
  logic [4:0]  tag_q, tag_nxt;

  logic [63:0] td_nxt;
  logic [7:0]  trem_nxt;
  logic        sof_nxt, eof_nxt, src_rdy_nxt, ack_nxt, drv_nxt;

  logic        xfer, capture, advance, more, load_beat1;
  logic [63:0] beat1, beat2;

  assign xfer    = !trn.trn_tsrc_rdy_n && !trn.trn_tdst_rdy_n;
  assign capture = (state == ST_IDLE) && read_chunk;
  assign advance = (state == ST_HDR2) && xfer;
  assign more    = (rem_q != 3'd1);

  // The header builder sees the post-update tag/address so a back-to-back
  // beat1 can be loaded in the same cycle beat2 is accepted.
  always_comb begin
    addr_nxt   = addr_q;
    sub_dw_nxt = sub_dw_q;
    rem_nxt    = rem_q;
    tag_nxt    = tag_q;
    if (capture) begin
      addr_nxt   = huge_page_addr_read_from;
      sub_dw_nxt = sub_req_dw(cfg_max_rd_req_size);
      rem_nxt    = sub_req_count(cfg_max_rd_req_size);
    end else if (advance) begin
      addr_nxt = addr_q + {52'd0, sub_dw_q, 2'b00};
      rem_nxt  = rem_q - 3'd1;
      tag_nxt  = tag_q + 5'd1;
    end
  end

  mrd_hdr_build u_hdr (
    .length       (sub_dw_q),
    .tag          (tag_nxt),
    .requester_id (cfg_completer_id),
    .addr         (addr_nxt[63:2]),
    .beat1        (beat1),
    .beat2        (beat2)
  );

  always_comb begin
    state_nxt   = state;
    td_nxt      = trn.trn_td;
    trem_nxt    = trn.trn_trem_n;
    sof_nxt     = trn.trn_tsof_n;
    eof_nxt     = trn.trn_teof_n;
    src_rdy_nxt = trn.trn_tsrc_rdy_n;
    ack_nxt     = 1'b0;
    drv_nxt     = driving_interface;
    load_beat1  = 1'b0;

    case (state)
      ST_IDLE: if (read_chunk) state_nxt = ST_ARB;
      ST_ARB: begin
        if (my_turn && trn.trn_tbuf_av_np) begin
          state_nxt  = ST_HDR1;
          drv_nxt    = 1'b1;
          load_beat1 = 1'b1;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          state_nxt = ST_HDR2;
          td_nxt    = beat2;
          sof_nxt   = 1'b1;
          eof_nxt   = 1'b0;
        end
      end
      ST_HDR2: begin
        if (xfer) begin
          if (more && trn.trn_tbuf_av_np) begin
            state_nxt  = ST_HDR1;
            load_beat1 = 1'b1;
          end else if (more) begin
            state_nxt   = ST_NPWAIT;
            src_rdy_nxt = 1'b1;
            eof_nxt     = 1'b1;
          end else begin
            state_nxt   = ST_ACK;
            src_rdy_nxt = 1'b1;
            eof_nxt     = 1'b1;
            ack_nxt     = 1'b1;
            drv_nxt     = 1'b0;
          end
        end
      end
      ST_NPWAIT: begin
        if (trn.trn_tbuf_av_np) begin
          state_nxt  = ST_HDR1;
          load_beat1 = 1'b1;
        end
      end
      ST_ACK:  state_nxt = ST_DONE;
      ST_DONE: if (!read_chunk) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (load_beat1) begin
      td_nxt      = beat1;
      trem_nxt    = '0;
      sof_nxt     = 1'b0;
      eof_nxt     = 1'b1;
      src_rdy_nxt = 1'b0;
    end
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      addr_q             <= '0;
      sub_dw_q           <= '0;
      rem_q              <= '0;
      tag_q              <= '0;
      trn.trn_td         <= '0;
      trn.trn_trem_n     <= '1;
      trn.trn_tsof_n     <= 1'b1;
      trn.trn_teof_n     <= 1'b1;
      trn.trn_tsrc_rdy_n <= 1'b1;
      read_chunk_ack     <= 1'b0;
      driving_interface  <= 1'b0;
    end else begin
      state              <= state_nxt;
      addr_q             <= addr_nxt;
      sub_dw_q           <= sub_dw_nxt;
      rem_q              <= rem_nxt;
      tag_q              <= tag_nxt;
      trn.trn_td         <= td_nxt;
      trn.trn_trem_n     <= trem_nxt;
      trn.trn_tsof_n     <= sof_nxt;
      trn.trn_teof_n     <= eof_nxt;
      trn.trn_tsrc_rdy_n <= src_rdy_nxt;
      read_chunk_ack     <= ack_nxt;
      driving_interface  <= drv_nxt;
    end
  end

endmodule

// File: tb/tb_mrd_tlp_sender.sv
// Randomized bench for mrd_tlp_sender: a chunk-level model predicts every
// MRd64 TLP (address, length, tag) and the single ack per chunk.
module tb_mrd_tlp_sender;

  logic        trn_clk = 1'b0;
  logic        reset_n;
  logic        read_chunk;
  logic [63:0] huge_page_addr_read_from;
  logic        read_chunk_ack;
  logic [15:0] cfg_completer_id;
  logic [2:0]  cfg_max_rd_req_size;
  logic        my_turn;
  logic        driving_interface;

  mrd_tlp_sender_if tx ();

  mrd_tlp_sender dut (
    .trn_clk                  (trn_clk),
    .reset_n                  (reset_n),
    .read_chunk               (read_chunk),
    .huge_page_addr_read_from (huge_page_addr_read_from),
    .read_chunk_ack           (read_chunk_ack),
    .cfg_completer_id         (cfg_completer_id),
    .cfg_max_rd_req_size      (cfg_max_rd_req_size),
    .trn                      (tx.master),
    .my_turn                  (my_turn),
    .driving_interface        (driving_interface)
  );

  always #5 trn_clk = ~trn_clk;

  typedef struct {
    logic [63:0] b1;
    logic [63:0] b2;
  } tlp_t;

  tlp_t obs_q[$];
  tlp_t exp_q[$];
  tlp_t mon_t;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_cycles = 0;
  int   model_tag  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Chunk model: 512 bytes split into equal sub-requests, tags counted mod 32.
  task automatic model_chunk(input logic [2:0] mrrs, input logic [63:0] addr);
    int unsigned bytes;
    int unsigned n;
    tlp_t t;
    bytes = (mrrs == 3'd0) ? 128 : (mrrs == 3'd1) ? 256 : 512;
    n = 512 / bytes;
    for (int unsigned i = 0; i < n; i++) begin
      t.b1 = {32'h2000_0000 + 32'(bytes / 4), cfg_completer_id, 8'(model_tag % 32), 8'hFF};
      t.b2 = addr + 64'(i * bytes);
      exp_q.push_back(t);
      model_tag++;
    end
  endtask

  task automatic compare_chunk(input int exp_acks);
    tlp_t e;
    tlp_t o;
    check("tlp_count", 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check("beat1", o.b1, e.b1);
      check("beat2", o.b2, e.b2);
    end
    exp_q.delete();
    obs_q.delete();
    check("ack_cycles", 64'(ack_cycles), 64'(exp_acks));
    ack_cycles = 0;
  endtask

  // Bus monitor: collects transferred TLPs and checks per-cycle bus rules.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_td;
  logic [10:0] prev_ctl;
  logic [63:0] cur_hdr;

  always @(negedge trn_clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (read_chunk_ack) ack_cycles++;
      if (!driving_interface)
        check("srcrdy_idle", 64'(tx.trn_tsrc_rdy_n), 64'(1));
      if (prev_stall) begin
        check("hold_td", tx.trn_td, prev_td);
        check("hold_ctl", 64'({tx.trn_trem_n, tx.trn_tsof_n, tx.trn_teof_n, tx.trn_tsrc_rdy_n}),
              64'(prev_ctl));
      end
      prev_stall = !tx.trn_tsrc_rdy_n && tx.trn_tdst_rdy_n;
      prev_td    = tx.trn_td;
      prev_ctl   = {tx.trn_trem_n, tx.trn_tsof_n, tx.trn_teof_n, tx.trn_tsrc_rdy_n};
      if (!tx.trn_tsrc_rdy_n && !tx.trn_tdst_rdy_n) begin
        check("trem", 64'(tx.trn_trem_n), 64'(0));
        if (!tx.trn_tsof_n) begin
          check("beat1_eof", 64'(tx.trn_teof_n), 64'(1));
          cur_hdr = tx.trn_td;
        end else begin
          check("beat2_eof", 64'(tx.trn_teof_n), 64'(0));
          mon_t.b1 = cur_hdr;
          mon_t.b2 = tx.trn_td;
          obs_q.push_back(mon_t);
        end
      end
    end
  end

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  // mode: 0 clean, 1 random stalls, 2 beat2 backpressure, 3 no grant,
  // 4 np-buffer gap between sub-requests, 5 request held after ack.
  task automatic run_chunk(input logic [2:0] mrrs, input logic [63:0] addr, input int mode);
    int cyc;
    int hold;
    bit acked;
    bit stalled;
    model_chunk(mrrs, addr);
    cfg_max_rd_req_size      = mrrs;
    huge_page_addr_read_from = addr;
    read_chunk               = 1'b1;
    my_turn                  = (mode != 3);
    tx.trn_tbuf_av_np        = 1'b1;
    tx.trn_tdst_rdy_n        = 1'b0;
    cyc = 0; hold = 0; acked = 0; stalled = 0;
    while (!acked && cyc < 2000) begin
      tick();
      cyc++;
      if (cyc == 1) cfg_max_rd_req_size = 3'($urandom);
      if (read_chunk_ack) begin
        acked = 1;
        if (mode != 5) read_chunk = 1'b0;
      end
      case (mode)
        1: begin
          tx.trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
          my_turn           = ($urandom_range(0, 3) != 0);
          tx.trn_tbuf_av_np = ($urandom_range(0, 3) != 0);
        end
        2: begin
          if (hold > 0) begin
            hold--;
            if (hold == 0) tx.trn_tdst_rdy_n = 1'b0;
          end else if (!stalled && !tx.trn_tsrc_rdy_n && !tx.trn_teof_n) begin
            tx.trn_tdst_rdy_n = 1'b1;
            hold = 5;
            stalled = 1;
          end
        end
        3: begin
          if (cyc < 10) begin
            check("nogrant_drive", 64'(driving_interface), 64'(0));
            check("nogrant_sof", 64'(tx.trn_tsof_n), 64'(1));
          end else begin
            my_turn = 1'b1;
          end
        end
        4: begin
          if (hold > 0) begin
            check("npwait_src", 64'(tx.trn_tsrc_rdy_n), 64'(1));
            if (obs_q.size() < exp_q.size())
              check("npwait_drive", 64'(driving_interface), 64'(1));
            hold--;
            if (hold == 0) tx.trn_tbuf_av_np = 1'b1;
          end else if (!tx.trn_tsrc_rdy_n && !tx.trn_teof_n && tx.trn_tbuf_av_np) begin
            tx.trn_tbuf_av_np = 1'b0;
            hold = 6;
          end
        end
        default: ;
      endcase
    end
    check("ack_seen", 64'(acked), 64'(1));
    if (mode == 5) begin
      repeat (5) tick();
      read_chunk = 1'b0;
    end
    my_turn           = 1'b1;
    tx.trn_tbuf_av_np = 1'b1;
    tx.trn_tdst_rdy_n = 1'b0;
    repeat (3) tick();
    compare_chunk(1);
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, "_td"},   tx.trn_td, 64'd0);
    check({where, "_trem"}, 64'(tx.trn_trem_n), 64'hFF);
    check({where, "_sof"},  64'(tx.trn_tsof_n), 64'(1));
    check({where, "_eof"},  64'(tx.trn_teof_n), 64'(1));
    check({where, "_src"},  64'(tx.trn_tsrc_rdy_n), 64'(1));
    check({where, "_ack"},  64'(read_chunk_ack), 64'(0));
    check({where, "_drv"},  64'(driving_interface), 64'(0));
  endtask

  logic [63:0] a;
  bit          found;

  initial begin
    reset_n                  = 1'b0;
    read_chunk               = 1'b0;
    huge_page_addr_read_from = '0;
    cfg_completer_id         = 16'hA5C3;
    cfg_max_rd_req_size      = 3'd0;
    my_turn                  = 1'b0;
    tx.trn_tbuf_av_np        = 1'b0;
    tx.trn_tdst_rdy_n        = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    // Single 512 B TLP, cycle-exact latency and ack timing.
    my_turn = 1'b1; tx.trn_tbuf_av_np = 1'b1; tx.trn_tdst_rdy_n = 1'b0;
    cfg_max_rd_req_size = 3'd2;
    huge_page_addr_read_from = 64'h0000_0001_0000_0200;
    model_chunk(3'd2, 64'h0000_0001_0000_0200);
    read_chunk = 1'b1;
    tick();
    check("lat1_sof", 64'(tx.trn_tsof_n), 64'(1));
    tick();
    check("lat2_sof", 64'(tx.trn_tsof_n), 64'(0));
    check("lat2_beat1", tx.trn_td, 64'h2000_0080_A5C3_00FF);
    check("lat2_drv", 64'(driving_interface), 64'(1));
    tick();
    check("lat3_beat2", tx.trn_td, 64'h0000_0001_0000_0200);
    check("lat3_eof", 64'(tx.trn_teof_n), 64'(0));
    tick();
    check("lat4_ack", 64'(read_chunk_ack), 64'(1));
    check("lat4_drv", 64'(driving_interface), 64'(0));
    read_chunk = 1'b0;
    tick();
    check("lat5_ack", 64'(read_chunk_ack), 64'(0));
    repeat (2) tick();
    compare_chunk(1);

    run_chunk(3'd0, 64'h0000_0000_0000_1000, 0);
    run_chunk(3'd0, 64'h0000_0000_FFFF_FE00, 0);
    run_chunk(3'd2, 64'h0000_0002_0000_0400, 2);
    run_chunk(3'd1, 64'h1234_5678_9ABC_DE00, 2);
    run_chunk(3'd1, 64'h0000_0000_0004_0000, 3);
    run_chunk(3'd0, 64'h0000_0003_0000_0600, 4);
    run_chunk(3'd1, 64'h0000_0000_0008_0200, 4);
    run_chunk(3'd0, 64'h0000_0000_0010_0000, 5);

    for (int i = 0; i < 12; i++) begin
      a = {$urandom, $urandom};
      a[8:0] = '0;
      run_chunk(3'($urandom), a, 1);
    end

    for (int i = 0; i < 33; i++) begin
      a = {$urandom, $urandom};
      a[8:0] = '0;
      run_chunk(3'd2, a, 0);
    end

    // Abandon a chunk by resetting while beat2 is on the bus.
    cfg_max_rd_req_size = 3'd0;
    huge_page_addr_read_from = 64'h0000_0000_0020_0000;
    read_chunk = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (!tx.trn_tsrc_rdy_n && !tx.trn_teof_n) found = 1;
    end
    check("hdr2_reached", 64'(found), 64'(1));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    read_chunk = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("midrst_no_ack", 64'(ack_cycles), 64'(0));
    check("midrst_no_tlp", 64'(obs_q.size()), 64'(0));
    obs_q.delete();
    ack_cycles = 0;
    model_tag = 0;
    run_chunk(3'd0, 64'h0000_0000_0030_0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
